// File: rtl/hall_sensor_generator.sv
// Hall sensor emulator: steps a 3-bit commutation pattern at a programmable
// rate, tracks signed step position and flags each revolution wrap.
module hall_sensor_generator #(
    parameter int unsigned MIN_PERIOD     = 4,
    parameter int unsigned DEFAULT_PERIOD = 10,
    parameter int unsigned STEPS_PER_REV  = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        direction,
    input  logic        period_load,
    input  logic [31:0] period,
    output logic        hall_sensor1,
    output logic        hall_sensor2,
    output logic        hall_sensor3,
    output logic        step_strobe,
    output logic        rev_pulse,
    output logic [31:0] step_count,
    output logic        period_pending,
    output logic        running
);

    localparam int unsigned PW           = 32;
    localparam int unsigned IDX_W        = 3;
    localparam int unsigned REV_W        = (STEPS_PER_REV > 1) ? $clog2(STEPS_PER_REV) : 1;
    localparam int unsigned RESET_PERIOD = (DEFAULT_PERIOD > MIN_PERIOD) ? DEFAULT_PERIOD : MIN_PERIOD;
    localparam logic [PW-1:0]    MIN_P   = PW'(MIN_PERIOD);
    localparam logic [PW-1:0]    RST_P   = PW'(RESET_PERIOD);
    localparam logic [REV_W-1:0] REV_TOP = REV_W'(STEPS_PER_REV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(5);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    timer_q, timer_d;
    logic [PW-1:0]    active_q, active_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic             pend_flag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [PW-1:0]    count_d;
    logic [2:0]       hall_d;
    logic             strobe_d;
    logic             revp_d;
    logic [PW-1:0]    load_val_c;
    logic             boundary_c;

    // Commutation table, {hall_sensor3, hall_sensor2, hall_sensor1}
    function automatic logic [2:0] hall_pattern(input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    hall_pattern = 3'b001;
            3'd1:    hall_pattern = 3'b011;
            3'd2:    hall_pattern = 3'b010;
            3'd3:    hall_pattern = 3'b110;
            3'd4:    hall_pattern = 3'b100;
            3'd5:    hall_pattern = 3'b101;
            default: hall_pattern = 3'b001;
        endcase
    endfunction

    // Requested period clamped to the minimum hold time
    always_comb begin
        load_val_c = (period < MIN_P) ? MIN_P : period;
    end

    // Next-state, timer, stepping and period bookkeeping
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_flag_d = period_pending;
        idx_d       = idx_q;
        rev_d       = rev_q;
        count_d     = step_count;
        hall_d      = {hall_sensor3, hall_sensor2, hall_sensor1};
        strobe_d    = 1'b0;
        revp_d      = 1'b0;
        boundary_c  = (timer_q == active_q - PW'(1));

        if (period_load) begin
            pend_d      = load_val_c;
            pend_flag_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (enable) begin
                    state_d = RUN;
                end
                if (!period_load && period_pending) begin
                    active_d    = pend_q;
                    pend_flag_d = 1'b0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (boundary_c) begin
                    timer_d  = '0;
                    strobe_d = 1'b1;
                    if (direction) begin
                        idx_d   = (idx_q == IDX_TOP) ? '0 : idx_q + IDX_W'(1);
                        count_d = step_count + PW'(1);
                        if (rev_q == REV_TOP) begin
                            rev_d  = '0;
                            revp_d = 1'b1;
                        end else begin
                            rev_d = rev_q + REV_W'(1);
                        end
                    end else begin
                        idx_d   = (idx_q == '0) ? IDX_TOP : idx_q - IDX_W'(1);
                        count_d = step_count - PW'(1);
                        if (rev_q == '0) begin
                            rev_d  = REV_TOP;
                            revp_d = 1'b1;
                        end else begin
                            rev_d = rev_q - REV_W'(1);
                        end
                    end
                    hall_d = hall_pattern(idx_d);
                    // A load landing on the boundary governs the step starting now
                    if (period_load) begin
                        active_d    = load_val_c;
                        pend_flag_d = 1'b0;
                    end else if (period_pending) begin
                        active_d    = pend_q;
                        pend_flag_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + PW'(1);
                end
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            active_q       <= RST_P;
            pend_q         <= RST_P;
            period_pending <= 1'b0;
            idx_q          <= '0;
            rev_q          <= '0;
            step_count     <= '0;
            hall_sensor1   <= 1'b1;
            hall_sensor2   <= 1'b0;
            hall_sensor3   <= 1'b0;
            step_strobe    <= 1'b0;
            rev_pulse      <= 1'b0;
            running        <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            active_q       <= active_d;
            pend_q         <= pend_d;
            period_pending <= pend_flag_d;
            idx_q          <= idx_d;
            rev_q          <= rev_d;
            step_count     <= count_d;
            hall_sensor1   <= hall_d[0];
            hall_sensor2   <= hall_d[1];
            hall_sensor3   <= hall_d[2];
            step_strobe    <= strobe_d;
            rev_pulse      <= revp_d;
            running        <= (state_d == RUN);
        end
    end

endmodule

// File: tb/tb_hall_sensor_generator.sv
// Bench for hall_sensor_generator: expected step events are queued when
// stimulus is applied and matched against each step_strobe.
module tb_hall_sensor_generator;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        direction;
    logic        period_load;
    logic [31:0] period;
    logic        hall_sensor1, hall_sensor2, hall_sensor3;
    logic        step_strobe, rev_pulse;
    logic [31:0] step_count;
    logic        period_pending, running;

    hall_sensor_generator dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .direction     (direction),
        .period_load   (period_load),
        .period        (period),
        .hall_sensor1  (hall_sensor1),
        .hall_sensor2  (hall_sensor2),
        .hall_sensor3  (hall_sensor3),
        .step_strobe   (step_strobe),
        .rev_pulse     (rev_pulse),
        .step_count    (step_count),
        .period_pending(period_pending),
        .running       (running)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  hall;
        logic        rev;
        logic [31:0] count;
    } exp_t;

    typedef struct {
        logic        dir;
        logic [2:0]  hall;
        logic        rev;
        logic [31:0] count;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[12];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned k, c0, c1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push(input int unsigned c, input logic [2:0] h, input logic r, input logic [31:0] n);
        exp_t e;
        e.cyc = c; e.hall = h; e.rev = r; e.count = n;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected steps not seen within %0d cycles", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        enable      = 1'b0;
        direction   = 1'b1;
        period_load = 1'b0;
        period      = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_hall"}, {hall_sensor3, hall_sensor2, hall_sensor1}, 3'b001);
        check({tag, "_count"}, step_count, 32'd0);
        check({tag, "_running"}, running, 1'b0);
        check({tag, "_strobe"}, step_strobe, 1'b0);
        check({tag, "_rev"}, rev_pulse, 1'b0);
        check({tag, "_pending"}, period_pending, 1'b0);
    endtask

    // Monitor: each strobe consumes one expectation; outputs hold otherwise
    logic [2:0] prev_hall = 3'b001;
    logic       prev_rn   = 1'b0;
    logic [2:0] hall_now;
    exp_t       e_mon;
    always @(negedge clock) begin
        hall_now = {hall_sensor3, hall_sensor2, hall_sensor1};
        if (reset_n && prev_rn) begin
            if (step_strobe) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step: hall %b count %0h at cycle %0d, none expected",
                             hall_now, step_count, cyc);
                end else begin
                    e_mon = sb.pop_front();
                    check("step_cycle", cyc, e_mon.cyc);
                    check("step_hall", hall_now, e_mon.hall);
                    check("step_rev", rev_pulse, e_mon.rev);
                    check("step_count", step_count, e_mon.count);
                end
            end else begin
                check("hold_hall", hall_now, prev_hall);
                check("idle_rev", rev_pulse, 1'b0);
            end
        end
        prev_hall = hall_now;
        prev_rn   = reset_n;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 3'b011, 1'b0, 32'd1};
        vecs[1]  = '{1'b1, 3'b010, 1'b0, 32'd2};
        vecs[2]  = '{1'b1, 3'b110, 1'b0, 32'd3};
        vecs[3]  = '{1'b1, 3'b100, 1'b0, 32'd4};
        vecs[4]  = '{1'b1, 3'b101, 1'b0, 32'd5};
        vecs[5]  = '{1'b1, 3'b001, 1'b1, 32'd6};
        vecs[6]  = '{1'b0, 3'b101, 1'b1, 32'hFFFF_FFFF};
        vecs[7]  = '{1'b0, 3'b100, 1'b0, 32'hFFFF_FFFE};
        vecs[8]  = '{1'b0, 3'b110, 1'b0, 32'hFFFF_FFFD};
        vecs[9]  = '{1'b0, 3'b010, 1'b0, 32'hFFFF_FFFC};
        vecs[10] = '{1'b0, 3'b011, 1'b0, 32'hFFFF_FFFB};
        vecs[11] = '{1'b0, 3'b001, 1'b0, 32'hFFFF_FFFA};

        // Full revolution forward, then reverse, from reset at the default period
        for (int s = 0; s < 2; s++) begin
            do_reset();
            check_reset_state("reset");
            direction = vecs[s*6].dir;
            enable    = 1'b1;
            k = cyc;
            for (int j = 0; j < 6; j++)
                push(k + 1 + 10 * (j + 1), vecs[s*6+j].hall, vecs[s*6+j].rev, vecs[s*6+j].count);
            tick();
            check("running_rise", running, 1'b1);
            wait_drain(80, "rev_table");
            check("final_count", step_count, vecs[s*6+5].count);
            enable = 1'b0;
            tick();
            tick();
        end

        // Period change requested mid-step takes effect after the current hold
        do_reset();
        enable = 1'b1;
        k = cyc; c0 = k + 1;
        push(c0 + 10, 3'b011, 1'b0, 32'd1);
        push(c0 + 30, 3'b010, 1'b0, 32'd2);
        push(c0 + 50, 3'b110, 1'b0, 32'd3);
        while (cyc != c0 + 3) tick();
        period = 32'd20; period_load = 1'b1;
        tick();
        period_load = 1'b0;
        check("pend_after_load", period_pending, 1'b1);
        while (cyc != c0 + 9) tick();
        check("pend_before_boundary", period_pending, 1'b1);
        tick();
        check("pend_at_boundary", period_pending, 1'b0);
        wait_drain(60, "period_20");
        enable = 1'b0;
        tick();

        // Period below the minimum clamps; applied in IDLE on the next edge
        do_reset();
        period = 32'd1; period_load = 1'b1;
        tick();
        period_load = 1'b0;
        check("idle_pend_set", period_pending, 1'b1);
        tick();
        check("idle_pend_applied", period_pending, 1'b0);
        enable = 1'b1;
        k = cyc; c0 = k + 1;
        push(c0 + 4, 3'b011, 1'b0, 32'd1);
        push(c0 + 8, 3'b010, 1'b0, 32'd2);
        push(c0 + 12, 3'b110, 1'b0, 32'd3);
        wait_drain(30, "min_period");
        enable = 1'b0;
        tick();

        // Disable mid-step discards the partial timer
        do_reset();
        enable = 1'b1;
        k = cyc; c0 = k + 1;
        while (cyc != c0 + 7) tick();
        enable = 1'b0;
        tick();
        check("disable_running", running, 1'b0);
        repeat (15) tick();
        check("disable_hold", {hall_sensor3, hall_sensor2, hall_sensor1}, 3'b001);
        enable = 1'b1;
        k = cyc; c1 = k + 1;
        push(c1 + 10, 3'b011, 1'b0, 32'd1);
        push(c1 + 20, 3'b010, 1'b0, 32'd2);
        wait_drain(30, "reenable");

        // Asynchronous reset mid-step clears everything at once
        tick();
        tick();
        @(negedge clock);
        #3;
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        check_reset_state("async_reset");
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("post_reset_hall", {hall_sensor3, hall_sensor2, hall_sensor1}, 3'b001);
        check("post_reset_count", step_count, 32'd0);

        // Load on a step boundary, then a direction change mid-hold
        do_reset();
        enable = 1'b1;
        k = cyc; c0 = k + 1;
        push(c0 + 10, 3'b011, 1'b0, 32'd1);
        push(c0 + 16, 3'b001, 1'b0, 32'd0);
        push(c0 + 22, 3'b101, 1'b1, 32'hFFFF_FFFF);
        while (cyc != c0 + 9) tick();
        period = 32'd6; period_load = 1'b1;
        tick();
        period_load = 1'b0;
        check("boundary_load_pend", period_pending, 1'b0);
        while (cyc != c0 + 13) tick();
        direction = 1'b0;
        wait_drain(40, "boundary_dir");
        enable = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
